mole_scheduler: RTL and testbench

MOLE_SCHEDULER -- requirements
Module: mole_scheduler

---
 rtl/mole_scheduler.sv | 155 +++++++++++++++
 tb/tb_mole_scheduler.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: LFSR-placed moles, hit/miss/lives tracking.
// Define WAM_NO_REPEAT_EN to forbid the same position on consecutive moles.
module mole_scheduler #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        load_seed,
    input  logic [15:0] seed,
    input  logic [27:0] time_on,
    input  logic [27:0] time_between,
    input  logic [5:0]  max_moles,
    input  logic [3:0]  lives_init,
    input  logic        valid_key,
    input  logic [3:0]  key,
    output logic [8:0]  lights,
    output logic [3:0]  light_pos,
    output logic [5:0]  mole_count,
    output logic [5:0]  hits,
    output logic [5:0]  misses,
    output logic [3:0]  lives_left,
    output logic        done
);
    typedef enum logic [1:0] {IDLE, GAP, SHOW, DONE} state_t;

    state_t      state, state_nx;
    logic [27:0] timer, timer_nx;
    logic [3:0]  pos_q, pos_nx;
    logic [5:0]  moles_q, moles_nx;
    logic [5:0]  hits_q, hits_nx;
    logic [5:0]  miss_q, miss_nx;
    logic [3:0]  lives_q, lives_nx;
    logic [15:0] lfsr;
    logic [3:0]  pick_raw, pick;
    logic        hit, finish;

    function automatic logic [5:0] sat_inc(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            lfsr <= SEED;
        else if (load_seed)
            lfsr <= (seed == 16'd0) ? SEED : seed;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    always_comb begin
        pick_raw = (lfsr[3:0] >= 4'd9) ? lfsr[3:0] - 4'd9 : lfsr[3:0];
`ifdef WAM_NO_REPEAT_EN
        if (pick_raw == pos_q && moles_q != 6'd0)
            pick = (pick_raw == 4'd8) ? 4'd0 : pick_raw + 4'd1;
        else
            pick = pick_raw;
`else
        pick = pick_raw;
`endif
    end

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        pos_nx   = pos_q;
        moles_nx = moles_q;
        hits_nx  = hits_q;
        miss_nx  = miss_q;
        lives_nx = lives_q;
        hit      = 1'b0;
        finish   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = GAP;
                    timer_nx = '0;
                    moles_nx = '0;
                    hits_nx  = '0;
                    miss_nx  = '0;
                    lives_nx = lives_init;
                end
            end
            GAP: begin
                if (!start) begin
                    state_nx = IDLE;
                end else if (timer == time_between) begin
                    state_nx = SHOW;
                    timer_nx = '0;
                    pos_nx   = pick;
                    moles_nx = sat_inc(moles_q);
                end else begin
                    timer_nx = timer + 28'd1;
                end
            end
            SHOW: begin
                if (!start) begin
                    state_nx = IDLE;
                end else begin
                    hit = valid_key && (key == pos_q);
                    if (hit || timer == time_on) begin
                        if (hit) begin
                            hits_nx = sat_inc(hits_q);
                        end else begin
                            miss_nx = sat_inc(miss_q);
                            if (lives_init != 4'd0 && lives_q != 4'd0)
                                lives_nx = lives_q - 4'd1;
                        end
                        // a completed mole may end the game
                        finish = (max_moles != 6'd0 && moles_q == max_moles)
                              || (lives_init != 4'd0 && lives_nx == 4'd0);
                        state_nx = finish ? DONE : GAP;
                        timer_nx = '0;
                    end else begin
                        timer_nx = timer + 28'd1;
                    end
                end
            end
            DONE: begin
                if (!start)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            timer   <= '0;
            pos_q   <= '0;
            moles_q <= '0;
            hits_q  <= '0;
            miss_q  <= '0;
            lives_q <= '0;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            pos_q   <= pos_nx;
            moles_q <= moles_nx;
            hits_q  <= hits_nx;
            miss_q  <= miss_nx;
            lives_q <= lives_nx;
        end
    end

    assign lights     = (state == SHOW) ? (9'd1 << pos_q) : 9'd0;
    assign light_pos  = pos_q;
    assign mole_count = moles_q;
    assign hits       = hits_q;
    assign misses     = miss_q;
    assign lives_left = lives_q;
    assign done       = (state == DONE);
endmodule

// File: tb/tb_mole_scheduler.sv
// Randomized bench for mole_scheduler against a countdown-based game model.
`timescale 1ns/1ps
module tb_mole_scheduler;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        load_seed = 1'b0;
    logic [15:0] seed = '0;
    logic [27:0] time_on = '0;
    logic [27:0] time_between = '0;
    logic [5:0]  max_moles = '0;
    logic [3:0]  lives_init = '0;
    logic        valid_key = 1'b0;
    logic [3:0]  key = '0;
    logic [8:0]  lights;
    logic [3:0]  light_pos;
    logic [5:0]  mole_count, hits, misses;
    logic [3:0]  lives_left;
    logic        done;

    mole_scheduler #(.SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .load_seed(load_seed),
        .seed(seed), .time_on(time_on), .time_between(time_between),
        .max_moles(max_moles), .lives_init(lives_init),
        .valid_key(valid_key), .key(key), .lights(lights),
        .light_pos(light_pos), .mole_count(mole_count), .hits(hits),
        .misses(misses), .lives_left(lives_left), .done(done)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // model: game in progress / lit / finished, cycles left in current phase
    bit          m_game, m_lit, m_done;
    int          m_left;
    int          m_pos, m_moles, m_hits, m_miss, m_lives;
    logic [15:0] m_lfsr;
    int          pv_cnt, pv_pos;
    int          seq_buf[8];
    int          seq_ref[8];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int sat(input int v);
        return (v >= 63) ? 63 : v + 1;
    endfunction

    task automatic model_reset();
        m_game = 0; m_lit = 0; m_done = 0; m_left = 0;
        m_pos = 0; m_moles = 0; m_hits = 0; m_miss = 0; m_lives = 0;
        m_lfsr = SEED;
    endtask

    task automatic model_step();
        logic [15:0] old;
        int p;
        bit h, fin;
        old = m_lfsr;
        m_lfsr = load_seed ? ((seed == 0) ? SEED : seed) : lfsr_next(m_lfsr);
        if (m_done) begin
            if (!start) m_done = 0;
        end else if (!m_game) begin
            if (start) begin
                m_game = 1; m_lit = 0; m_left = int'(time_between) + 1;
                m_moles = 0; m_hits = 0; m_miss = 0; m_lives = int'(lives_init);
            end
        end else if (!start) begin
            m_game = 0;
        end else if (!m_lit) begin
            if (m_left == 1) begin
                p = int'(old[3:0]) % 9;
`ifdef WAM_NO_REPEAT_EN
                if (p == m_pos && m_moles != 0) p = (p + 1) % 9;
`endif
                m_pos = p; m_moles = sat(m_moles);
                m_lit = 1; m_left = int'(time_on) + 1;
            end else m_left--;
        end else begin
            h = valid_key && (int'(key) == m_pos);
            if (h || m_left == 1) begin
                if (h) m_hits = sat(m_hits);
                else begin
                    m_miss = sat(m_miss);
                    if (lives_init != 0 && m_lives > 0) m_lives--;
                end
                fin = (max_moles != 0 && m_moles == int'(max_moles))
                   || (lives_init != 0 && m_lives == 0);
                if (fin) begin m_game = 0; m_done = 1; end
                else begin m_lit = 0; m_left = int'(time_between) + 1; end
            end else m_left--;
        end
    endtask

    task automatic compare_all();
        int el;
        el = (m_game && m_lit) ? (1 << m_pos) : 0;
        chk("lights", lights, el);
        chk("light_pos", light_pos, m_pos);
        chk("mole_count", mole_count, m_moles);
        chk("hits", hits, m_hits);
        chk("misses", misses, m_miss);
        chk("lives_left", lives_left, m_lives);
        chk("done", done, m_done);
`ifdef WAM_NO_REPEAT_EN
        if (int'(mole_count) == pv_cnt + 1 && pv_cnt != 0)
            chk("no_repeat", light_pos != pv_pos, 1);
`endif
        pv_cnt = mole_count;
        pv_pos = light_pos;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic go_idle();
        start = 0; valid_key = 0; load_seed = 0;
        tick();
    endtask

    task automatic set_game(input int tb, input int to, input int mm, input int li);
        time_between = 28'(tb); time_on = 28'(to);
        max_moles = 6'(mm); lives_init = 4'(li);
    endtask

    task automatic wait_lit(input string name);
        for (int i = 0; i < 60 && lights == 0; i++) tick();
        chk(name, lights != 0, 1);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 80 && !done; i++) tick();
        chk(name, done, 1);
    endtask

    task automatic mid_reset();
        reset = 0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic seed_pos(input logic [15:0] sd, input int tb, input int exp);
        go_idle();
        set_game(tb, 3, 1, 0);
        seed = sd; load_seed = 1; start = 1;
        tick();
        load_seed = 0;
        repeat (tb + 1) tick();
        chk("seed_pos", light_pos, exp);
        chk("seed_lights", lights, 1 << exp);
    endtask

    task automatic run_seq();
        int n, pc;
        go_idle();
        set_game(2, 1, 0, 0);
        seed = 16'h5A5A; load_seed = 1; start = 1;
        tick();
        load_seed = 0;
        n = 0; pc = mole_count;
        for (int i = 0; i < 100 && n < 8; i++) begin
            tick();
            if (int'(mole_count) != pc) begin
                seq_buf[n] = light_pos; n++; pc = mole_count;
            end
        end
        chk("seq_len", n, 8);
    endtask

    initial begin
        int lit, first_lit, done_at, lives1;
        model_reset();
        pv_cnt = 0; pv_pos = 0;
        repeat (2) @(negedge clk);
        compare_all();
        chk("reset_lights", lights, 0);
        chk("reset_done", done, 0);
        reset = 1;
        tick();

        seed_pos(16'h000D, 0, 4);
        seed_pos(16'h0000, 0, 1);
        seed_pos(16'h0010, 1, 8);

        // 4 dark, 6 lit, twice, then done
        go_idle();
        set_game(3, 5, 2, 0);
        start = 1;
        lit = 0; first_lit = 0; done_at = 0;
        for (int i = 1; i <= 40 && done_at == 0; i++) begin
            tick();
            if (lights != 0) begin
                lit++;
                if (first_lit == 0) first_lit = i;
            end
            if (done) done_at = i;
        end
        chk("lit_cycles", lit, 12);
        chk("first_lit", first_lit, 5);
        chk("done_at", done_at, 21);
        chk("timeout_misses", misses, 2);

        // lives countdown
        go_idle();
        set_game(1, 1, 0, 2);
        start = 1;
        lives1 = -1;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (misses == 1 && lives1 < 0) lives1 = lives_left;
        end
        chk("lives_after_1", lives1, 1);
        chk("lives_done", done, 1);
        chk("lives_end", lives_left, 0);
        chk("lives_misses", misses, 2);

        // hit two cycles into SHOW
        go_idle();
        set_game(2, 5, 0, 0);
        start = 1;
        wait_lit("hit_wait");
        tick(); tick();
        valid_key = 1; key = 4'(m_pos);
        tick();
        valid_key = 0;
        chk("hit_dark", lights, 0);
        chk("hit_count", hits, 1);
        tick(); tick();
        chk("regap_dark", lights, 0);
        tick();
        chk("regap_lit", lights != 0, 1);

        // wrong key then timeout; correct key on timeout cycle
        go_idle();
        set_game(1, 2, 1, 0);
        start = 1;
        wait_lit("wrong_wait");
        valid_key = 1; key = 4'((m_pos + 1) % 9);
        tick();
        valid_key = 0;
        wait_done("wrong_done");
        chk("wrong_hits", hits, 0);
        chk("wrong_misses", misses, 1);
        go_idle();
        start = 1;
        wait_lit("edge_wait");
        tick(); tick();
        valid_key = 1; key = 4'(m_pos);
        tick();
        valid_key = 0;
        chk("edge_hits", hits, 1);
        chk("edge_misses", misses, 0);
        chk("edge_done", done, 1);

        // abort mid-GAP, then reset mid-SHOW
        go_idle();
        set_game(4, 1, 0, 3);
        start = 1;
        repeat (9) tick();
        start = 0;
        tick();
        chk("abort_moles", mole_count, 1);
        chk("abort_misses", misses, 1);
        chk("abort_lives", lives_left, 2);
        start = 1;
        repeat (6) tick();
        chk("pre_reset_lit", lights != 0, 1);
        mid_reset();
        chk("rst_lights", lights, 0);
        chk("rst_moles", mole_count, 0);

        // saturation
        go_idle();
        set_game(0, 0, 0, 0);
        start = 1;
        for (int i = 0; i < 160; i++) begin
            valid_key = 1; key = 4'(m_pos);
            tick();
        end
        valid_key = 0;
        chk("sat_hits", hits, 63);
        chk("sat_moles", mole_count, 63);
        go_idle();
        start = 1;
        repeat (160) tick();
        chk("sat_misses", misses, 63);

        // same seed twice
        run_seq();
        seq_ref = seq_buf;
        run_seq();
        for (int i = 0; i < 8; i++) chk("seq_repeat", seq_buf[i], seq_ref[i]);

        // random epochs
        for (int e = 0; e < 14; e++) begin
            go_idle();
            set_game($urandom_range(0, 5), $urandom_range(0, 5),
                     $urandom_range(0, 6), $urandom_range(0, 3));
            if (e % 4 == 3) begin max_moles = 0; lives_init = 0; end
            for (int c = 0; c < 300; c++) begin
                start = ($urandom_range(0, 99) < 97);
                load_seed = ($urandom_range(0, 49) == 0);
                seed = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
                valid_key = ($urandom_range(0, 2) == 0);
                key = $urandom_range(0, 1) ? 4'(m_pos) : 4'($urandom_range(0, 15));
                tick();
                if (e == 5 && c == 150) mid_reset();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
